// File: rtl/sample_framer_if.sv
// Handshake bundle between the SAR sample source, the framer and uart_tx.
// slave: the framer side. master: the side that drives samples and busy.
interface sample_framer_if;
    logic [11:0] sample_i;
    logic        sample_valid_i;
    logic        sample_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_en_o;
    logic        tx_busy_i;
    logic        frame_active_o;

    modport slave (
        input  sample_i, sample_valid_i, tx_busy_i,
        output sample_ready_o, tx_data_o, tx_en_o, frame_active_o
    );

    modport master (
        output sample_i, sample_valid_i, tx_busy_i,
        input  sample_ready_o, tx_data_o, tx_en_o, frame_active_o
    );
endinterface

// File: rtl/sample_framer.sv
// sample_framer: buffers 12-bit ADC samples and sends each one to uart_tx as a
// 3-byte frame {HEADER, {seq, msbs}, lsbs}, one byte per en/busy handshake.
module sample_framer #(
    parameter int         DEPTH  = 4,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input logic             clk_i,
    input logic             reset_i,
    sample_framer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] WAIT_HI = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    logic [11:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_q, ready_d;

    logic [1:0]    state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [11:0]   frame_q, frame_d;
    logic [3:0]    seq_q, seq_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_en_q, tx_en_d;
    logic          active_q, active_d;

    logic          push, pop;
    logic [7:0]    cur_byte;

    // ready is registered, so a full FIFO refuses pushes even on a pop edge
    assign push = bus.sample_valid_i && ready_q;
    assign pop  = (state_q == IDLE) && (count_q != '0);

    // Byte currently selected by the frame index
    always_comb begin
        cur_byte = HEADER;
        case (idx_q)
            2'd1:    cur_byte = {seq_q, frame_q[11:8]};
            2'd2:    cur_byte = frame_q[7:0];
            default: cur_byte = HEADER;
        endcase
    end

    // FIFO pointer/occupancy next state; pointers wrap naturally (DEPTH is 2^AW)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);
        ready_d = (count_d != FULL_CNT);
    end

    // Frame FSM: pop, then per byte wait for idle uart, strobe, see busy rise and fall
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        frame_d   = frame_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    frame_d = mem_q[rd_ptr_q];
                    idx_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!bus.tx_busy_i) begin
                    tx_data_d = cur_byte;
                    tx_en_d   = 1'b1;
                    state_d   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.tx_busy_i) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!bus.tx_busy_i) begin
                    if (idx_q == 2'd2) begin
                        seq_d   = seq_q + 4'd1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
    end

    // Sample storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= bus.sample_i;
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            frame_q   <= 12'h000;
            seq_q     <= 4'd0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            seq_q     <= seq_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            active_q  <= active_d;
        end
    end

    assign bus.sample_ready_o = ready_q;
    assign bus.tx_data_o      = tx_data_q;
    assign bus.tx_en_o        = tx_en_q;
    assign bus.frame_active_o = active_q;
endmodule
